noc_host_tx: RTL

Host-side packet transmitter for the device NoC link. It accepts 64-bit words from a host producer using the pushin/firstin/stopin word handshake, and buffers one or more complete messages. It serializes each message as a byte-wide write packet on the tod_ctl/tod_data link toward the permutation device. It is the initiator counterpart of the device's NoC interface and drives the link the device receives on.

---
 rtl/noc_host_tx_if.sv | 21 ++
 rtl/noc_host_tx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/noc_host_tx_if.sv
// Producer word handshake (pushin/firstin/din/stopin) and the byte-wide
// tod link toward the device, bundled for the host transmitter.
interface noc_host_tx_if;
  logic        pushin;
  logic        firstin;
  logic [63:0] din;
  logic        stopin;
  logic        tod_ctl;
  logic [7:0]  tod_data;
  logic        err;

  modport master (
    output pushin, firstin, din,
    input  stopin, tod_ctl, tod_data, err
  );

  modport slave (
    input  pushin, firstin, din,
    output stopin, tod_ctl, tod_data, err
  );
endinterface

// File: rtl/noc_host_tx.sv
// Host-side NoC transmitter: buffers whole messages of 64-bit words and
// serializes each as a header/address/data byte packet on the tod link.
module noc_host_tx #(
  parameter int unsigned WORDS = 25,
  parameter int unsigned DEPTH = 32,
  parameter logic [7:0]  ADDR  = 8'h00
) (
  input logic          clk,
  input logic          reset,
  noc_host_tx_if.slave bus
);
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [7:0]  HDR_BYTE  = {3'b011, 5'(WORDS - 1)};
  localparam logic [AW:0] FULL      = (AW + 1)'(DEPTH);
  localparam logic [AW:0] HIGH      = (AW + 1)'(DEPTH - 2);
  localparam logic [AW:0] MSG       = (AW + 1)'(WORDS);
  localparam logic [4:0]  LAST_WORD = 5'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, HDR, ADR, DAT} state_t;

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;
  state_t            state;
  state_t            state_nxt;
  logic [2:0]        bytecnt;
  logic [2:0]        bytecnt_nxt;
  logic [4:0]        wordcnt;
  logic [4:0]        wordcnt_nxt;
  logic              push;
  logic              pop;
  logic              drop;
  logic              orphan;
  logic              misplaced;
  logic [DATA_W:0]   head;
  logic [DATA_W-1:0] head_nxt;
  logic              ctl_nxt;
  logic [7:0]        data_nxt;

  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] w,
                                           input logic [2:0]        idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  always_comb begin
    state_nxt   = state;
    bytecnt_nxt = bytecnt;
    wordcnt_nxt = wordcnt;
    pop         = 1'b0;
    orphan      = 1'b0;
    misplaced   = 1'b0;
    head        = mem[rd_ptr];

    case (state)
      IDLE: begin
        // A head word without the first flag can never start a packet.
        if (count != '0 && !head[DATA_W]) begin
          pop    = 1'b1;
          orphan = 1'b1;
        end else if (head[DATA_W] && count >= MSG) begin
          state_nxt = HDR;
        end
      end
      HDR: state_nxt = ADR;
      ADR: begin
        state_nxt   = DAT;
        bytecnt_nxt = 3'd0;
        wordcnt_nxt = 5'd0;
      end
      DAT: begin
        bytecnt_nxt = bytecnt + 3'd1;
        if (bytecnt == 3'd7) begin
          pop         = 1'b1;
          misplaced   = head[DATA_W] && (wordcnt != 5'd0);
          wordcnt_nxt = wordcnt + 5'd1;
          if (wordcnt == LAST_WORD) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // When full, a same-edge pop frees the slot the push lands in.
    push      = bus.pushin && (count != FULL || pop);
    drop      = bus.pushin && !push;
    count_nxt = count + (AW + 1)'(push) - (AW + 1)'(pop);
    head_nxt  = pop ? mem[rd_ptr + 1'b1][DATA_W-1:0] : head[DATA_W-1:0];

    // Flits are registered from the next state so tod tracks the FSM edge.
    ctl_nxt  = 1'b1;
    data_nxt = 8'h00;
    case (state_nxt)
      HDR: data_nxt = HDR_BYTE;
      ADR: begin
        ctl_nxt  = 1'b0;
        data_nxt = ADDR;
      end
      DAT: begin
        ctl_nxt  = 1'b0;
        data_nxt = pick_byte(head_nxt, bytecnt_nxt);
      end
      default: begin
        ctl_nxt  = 1'b1;
        data_nxt = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.firstin, bus.din};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bytecnt      <= 3'd0;
      wordcnt      <= 5'd0;
      bus.stopin   <= 1'b0;
      bus.tod_ctl  <= 1'b1;
      bus.tod_data <= 8'h00;
      bus.err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      bytecnt      <= bytecnt_nxt;
      wordcnt      <= wordcnt_nxt;
      count        <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      bus.stopin   <= (count_nxt >= HIGH);
      bus.tod_ctl  <= ctl_nxt;
      bus.tod_data <= data_nxt;
      bus.err      <= drop | orphan | misplaced;
    end
  end
endmodule
